// File: rtl/regs_alu_wb.sv
// rtl/regs_alu_wb.sv - execute/write-back stage feeding the Regs_8_32 write port
// Optional sequential multiplier (op 101) enabled by macro ALU_SEQ_MUL_EN.
module regs_alu_wb #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             cr_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             WE,
    output logic [AW-1:0]    Addr_W,
    output logic [WIDTH-1:0] Di
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] di_q, di_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic             is_mul;

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (op)
            3'b000:  alu_res = A + B;
            3'b001:  alu_res = A - B;
            3'b010:  alu_res = A & B;
            3'b011:  alu_res = A | B;
            3'b100:  alu_res = A ^ B;
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            3'b111:  alu_res = A >> B[SW-1:0];
`ifdef ALU_SEQ_MUL_EN
            default: alu_res = '0;
`else
            default: alu_illegal = 1'b1;
`endif
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: multiplicand shifts left, multiplier drains LSB first.
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_next;
    logic [SW-1:0]    cnt_q;
    logic [AW-1:0]    rd_q;

    assign is_mul   = (op == 3'b101);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge cr_n) begin
        if (!cr_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
        end else if (state_q == S_IDLE && start) begin
            mcand_q  <= A;
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= rd;
        end else if (state_q == S_EXEC) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_next;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        di_d      = di_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    illegal_d = alu_illegal;
                    if (is_mul) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_WB;
                        if (!alu_illegal) begin
                            addr_d = rd;
                            di_d   = alu_res;
                        end
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_EXEC: begin
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = S_WB;
                    addr_d  = rd_q;
                    di_d    = acc_next;
                end
            end
`endif
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cr_n) begin
        if (!cr_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            di_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            di_q      <= di_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_WB);
    assign err    = (state_q == S_WB) && illegal_q;
    assign WE     = (state_q == S_WB) && !illegal_q;
    assign Addr_W = addr_q;
    assign Di     = di_q;
endmodule
